// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle core controller: state encoding,
// RV32I major-opcode constants, instruction classes and the select/cause
// encodings that leave the controller.
package core_ctrl_pkg;

  // Width of the memory wait counter; large enough for MEM_TIMEOUT up to 255.
  localparam int unsigned TMO_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // Major opcodes (inst[6:0]) recognised by the controller.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_LUI     = 4'd1,
    CLS_AUIPC   = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_JALR    = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_OP_IMM  = 4'd8,
    CLS_OP      = 4'd9
  } inst_class_t;

  // Immediate generator select.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  // Next-PC source.
  typedef enum logic [1:0] {
    PC_PLUS4   = 2'b00,
    PC_IMM     = 2'b01,
    PC_RS1_IMM = 2'b10
  } pc_sel_t;

  // Register-file write-back source.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

  // Classes that need a data-memory phase after EXEC.
  function automatic logic is_mem_class(inst_class_t cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Purely combinational decode of the major opcode into an instruction class,
// a legality flag and the immediate/ALU-operand selects that class needs.
module opcode_classifier
  import core_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output inst_class_t cls,
  output logic        legal,
  output imm_sel_t    imm_sel,
  output logic        alu_src_b
);

  // Map each legal opcode to its class and operand selects.
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    cls       = CLS_ILLEGAL;
    legal     = 1'b1;
    imm_sel   = IMM_I;
    alu_src_b = 1'b1;
    case (opcode)
      OPC_LUI:    begin cls = CLS_LUI;    imm_sel = IMM_U; end
      OPC_AUIPC:  begin cls = CLS_AUIPC;  imm_sel = IMM_U; end
      OPC_JAL:    begin cls = CLS_JAL;    imm_sel = IMM_J; end
      OPC_JALR:   cls = CLS_JALR;
      // Branch compare runs on rs1/rs2; the target uses the B immediate.
      OPC_BRANCH: begin cls = CLS_BRANCH; imm_sel = IMM_B; alu_src_b = 1'b0; end
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  begin cls = CLS_STORE;  imm_sel = IMM_S; end
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_OP:     begin cls = CLS_OP;     alu_src_b = 1'b0; end
      default: begin
        legal     = 1'b0;
        alu_src_b = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle control unit for an RV32I-style datapath. Sequences each
// instruction through FETCH/DECODE/EXEC[/MEM][/WB], bounds every memory wait
// with MEM_TIMEOUT, traps on illegal opcodes or memory timeouts, and counts
// retired instructions.
module core_control_fsm
  import core_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  // Counter value on the last permitted waiting cycle of a memory request.
  localparam logic [TMO_W-1:0] TIMEOUT_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  trap_cause_t      cause_q, cause_d;
  logic [31:0]      retired_q;
  logic             retire;
  logic             instr_done;

  inst_class_t cls;
  logic        cls_legal;
  imm_sel_t    cls_imm;
  logic        cls_alu_b;

  pc_sel_t  pc_sel_e;
  imm_sel_t imm_sel_e;
  wb_sel_t  wb_sel_e;

  // Only the major opcode steers control; the rest of IR feeds the datapath.
  logic unused_inst;
  assign unused_inst = ^inst[31:7];

  opcode_classifier u_classifier (
    .opcode    (inst[6:0]),
    .cls       (cls),
    .legal     (cls_legal),
    .imm_sel   (cls_imm),
    .alu_src_b (cls_alu_b)
  );

  // State, wait counter and trap cause registers; reset forces IDLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cause_d    = cause_q;
    retire     = 1'b0;
    instr_done = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_sel_e   = PC_PLUS4;
    imm_sel_e  = IMM_I;
    wb_sel_e   = WB_ALU;
    alu_src_b  = 1'b0;
    trap       = 1'b0;

    // Operand selects follow IR only while an instruction is being executed.
    if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
      imm_sel_e = cls_imm;
      alu_src_b = cls_alu_b;
    end

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          wait_d  = '0;
        end
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else begin
          wait_d = wait_q + TMO_W'(1);
          if (wait_q == TIMEOUT_LAST) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end

      ST_DECODE: begin
        if (cls_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end

      ST_EXEC: begin
        if (cls == CLS_BRANCH) begin
          pc_sel_e   = br_taken ? PC_IMM : PC_PLUS4;
          instr_done = 1'b1;
        end else if (is_mem_class(cls)) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            instr_done = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          wait_d = wait_q + TMO_W'(1);
          if (wait_q == TIMEOUT_LAST) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        case (cls)
          CLS_JAL: begin
            pc_sel_e = PC_IMM;
            wb_sel_e = WB_PC4;
          end
          CLS_JALR: begin
            pc_sel_e = PC_RS1_IMM;
            wb_sel_e = WB_PC4;
          end
          CLS_LOAD: wb_sel_e = WB_LOAD;
          default:  wb_sel_e = WB_ALU;
        endcase
      end

      ST_TRAP: begin
        // Sticky until reset; all strobes stay low.
        trap = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    // Common instruction-boundary handling: commit PC, count, and either
    // start the next fetch or park in IDLE when run has been dropped.
    if (instr_done) begin
      pc_write = 1'b1;
      retire   = 1'b1;
      wait_d   = '0;
      state_d  = run ? ST_FETCH : ST_IDLE;
    end
  end

  assign pc_sel     = pc_sel_e;
  assign imm_sel    = imm_sel_e;
  assign wb_sel     = wb_sel_e;
  assign busy       = (state_q != ST_IDLE);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule
